// File: rtl/am_lock_module.sv
// Alignment-marker lock for one PCS lane: finds two AMs one period apart, then tracks them.
// Optional macro AM_LOCK_ERR_CNT_EN builds a saturating invalid-AM counter on o_am_err_count.
module am_lock_module #(
  parameter int NB_DATA        = 66,
  parameter int AM_PERIOD      = 16384,
  parameter int N_LANES        = 20,
  parameter int NB_LANE_ID     = 5,
  parameter int NB_INVALID_CNT = 3
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_enable,
  input  logic                      i_valid,
  input  logic                      i_block_lock,
  input  logic [NB_DATA-1:0]        i_data,
  input  logic [NB_INVALID_CNT-1:0] i_rf_am_invalid_limit,
  output logic [NB_DATA-1:0]        o_data,
  output logic                      o_valid,
  output logic                      o_am_flag,
  output logic                      o_am_lock,
  output logic [NB_LANE_ID-1:0]     o_lane_id,
  output logic [15:0]               o_am_err_count,
  output logic [1:0]                o_state
);

  typedef enum logic [1:0] {LOCK_INIT, FIND_1ST, COUNT_1, LOCKED} state_t;

  localparam int CNT_W = (AM_PERIOD > 1) ? $clog2(AM_PERIOD) : 1;
  localparam int N_TBL = (N_LANES < 20) ? N_LANES : 20;
  localparam logic [CNT_W-1:0] SLOT_CNT = CNT_W'(AM_PERIOD - 1);

  // {M0,M1,M2} of each lane's marker; {M4,M5,M6} carry the bitwise inverse.
  localparam logic [23:0] AM_TBL [20] = '{
    24'hC16821, 24'h9D718E, 24'h594BE8, 24'h4D957B, 24'hF50709,
    24'hDD14C2, 24'h9A4A26, 24'h7B4566, 24'hA02476, 24'h68C9FB,
    24'hFD6C99, 24'hB99155, 24'h5CB9B2, 24'h1AF8BD, 24'h83C7CA,
    24'h3536CD, 24'hC4314C, 24'hADD6B7, 24'h5F662A, 24'hC0F0E5
  };

  state_t                    state;
  logic [CNT_W-1:0]          cnt;
  logic [NB_INVALID_CNT-1:0] inv_cnt;
  logic [NB_LANE_ID-1:0]     cand_id;
  logic                      am_match;
  logic [NB_LANE_ID-1:0]     am_id;
  logic                      at_slot;
  logic [NB_INVALID_CNT:0]   inv_next;
  logic [NB_INVALID_CNT:0]   limit_eff;

  always_comb begin
    am_match = 1'b0;
    am_id    = '0;
    if (i_data[65:64] == 2'b10) begin
      for (int i = 0; i < N_TBL; i++) begin
        if (i_data[63:40] == AM_TBL[i] && i_data[31:8] == ~AM_TBL[i]) begin
          am_match = 1'b1;
          am_id    = i[NB_LANE_ID-1:0];
        end
      end
    end
  end

  assign at_slot   = (cnt == SLOT_CNT);
  assign inv_next  = {1'b0, inv_cnt} + 1'b1;
  assign limit_eff = (i_rf_am_invalid_limit == '0) ? (NB_INVALID_CNT+1)'(1)
                                                  : {1'b0, i_rf_am_invalid_limit};
  assign o_state   = state;

`ifndef AM_LOCK_ERR_CNT_EN
  assign o_am_err_count = 16'h0000;
`endif

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state     <= LOCK_INIT;
      cnt       <= '0;
      inv_cnt   <= '0;
      cand_id   <= '0;
      o_data    <= '0;
      o_valid   <= 1'b0;
      o_am_flag <= 1'b0;
      o_am_lock <= 1'b0;
      o_lane_id <= '0;
`ifdef AM_LOCK_ERR_CNT_EN
      o_am_err_count <= 16'h0000;
`endif
    end else begin
      o_data    <= i_data;
      o_valid   <= i_valid;
      o_am_flag <= 1'b0;
      // Losing block lock or enable beats whatever the current slot would have decided.
      if (!i_enable || !i_block_lock) begin
        state     <= LOCK_INIT;
        o_am_lock <= 1'b0;
      end else begin
        case (state)
          LOCK_INIT: begin
            state     <= FIND_1ST;
            cnt       <= '0;
            inv_cnt   <= '0;
            o_am_lock <= 1'b0;
          end
          FIND_1ST: begin
            if (i_valid && am_match) begin
              cand_id <= am_id;
              cnt     <= '0;
              state   <= COUNT_1;
            end
          end
          COUNT_1: begin
            if (i_valid) begin
              if (at_slot) begin
                cnt <= '0;
                if (am_match && am_id == cand_id) begin
                  state     <= LOCKED;
                  o_am_lock <= 1'b1;
                  o_lane_id <= am_id;
                  o_am_flag <= 1'b1;
                  inv_cnt   <= '0;
                end else begin
                  state <= FIND_1ST;
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          LOCKED: begin
            if (i_valid) begin
              if (at_slot) begin
                cnt       <= '0;
                o_am_flag <= 1'b1;
                if (am_match && am_id == o_lane_id) begin
                  inv_cnt <= '0;
                end else begin
`ifdef AM_LOCK_ERR_CNT_EN
                  if (o_am_err_count != 16'hFFFF) o_am_err_count <= o_am_err_count + 1'b1;
`endif
                  if (inv_next >= limit_eff) begin
                    state     <= LOCK_INIT;
                    o_am_lock <= 1'b0;
                    inv_cnt   <= '0;
                  end else begin
                    inv_cnt <= inv_next[NB_INVALID_CNT-1:0];
                  end
                end
              end else begin
                cnt <= cnt + 1'b1;
              end
            end
          end
          default: state <= LOCK_INIT;
        endcase
      end
    end
  end

endmodule

// File: doc/am_lock_module.md
AM_LOCK_MODULE -- requirements
Module: am_lock_module

Interface
REQ-001 SHALL have parameters: NB_DATA, 66, coded block width; AM_PERIOD, 16384, valid blocks between alignment markers (AM) per lane; N_LANES, 20, number of AM encodings recognised; NB_LANE_ID, 5, lane-ID width; NB_INVALID_CNT, 3, invalid-AM limit width.
REQ-002 SHALL have port i_clock, input, 1, sole clock; reset is asynchronous and active-high.
REQ-003 SHALL have port i_reset, input, 1, asynchronous active-high reset.
REQ-004 SHALL have port i_enable, input, 1, when low the FSM holds in LOCK_INIT.
REQ-005 SHALL have port i_valid, input, 1, i_data qualifier.
REQ-006 SHALL have port i_block_lock, input, 1, block lock from the upstream block-sync lane.
REQ-007 SHALL have port i_data, input, NB_DATA, block-synced 66b block: [65:64] sync header, [63:56] M0 ... [7:0] M7.
REQ-008 SHALL have port i_rf_am_invalid_limit, input, NB_INVALID_CNT, consecutive bad AMs that cause unlock (0 treated as 1).
REQ-009 SHALL have ports o_data (output, NB_DATA) and o_valid (output, 1): i_data/i_valid delayed one cycle.
REQ-010 SHALL have port o_am_flag, output, 1, marks the o_data block sitting in an AM slot while locked.
REQ-011 SHALL have port o_am_lock, output, 1, AM lock status.
REQ-012 SHALL have port o_lane_id, output, NB_LANE_ID, PCS lane number captured at lock.
REQ-013 SHALL have port o_am_err_count, output, 16, invalid-AM counter (see Configuration).

Function
REQ-014 AM match SHALL be: i_data[65:64]==2'b10, {M0,M1,M2} equal to a lane's IEEE 802.3 Table 82-3 value, and {M4,M5,M6} equal to its bitwise inverse; BIP3/BIP7 ignored.
REQ-015 Only blocks with i_valid=1 SHALL be evaluated or counted; i_valid=0 cycles freeze counter and FSM.
REQ-016 FSM states SHALL be LOCK_INIT, FIND_1ST, COUNT_1, LOCKED.
REQ-017 LOCK_INIT -> FIND_1ST when i_enable & i_block_lock; clears counter, invalid count, o_am_lock.
REQ-018 FIND_1ST: first matching block captures candidate lane ID, counter cleared to 0, -> COUNT_1.
REQ-019 Counter SHALL increment per valid non-slot block; slot = valid block with counter==AM_PERIOD-1, i.e. the AM_PERIOD-th block after the last AM; counter returns to 0 on every slot.
REQ-020 COUNT_1 at slot: match with same lane ID -> LOCKED, o_am_lock=1, o_lane_id updated; otherwise -> FIND_1ST, with no re-evaluation of the slot block.
REQ-021 LOCKED at slot: match with locked ID clears invalid count; else invalid count +1; reaching i_rf_am_invalid_limit -> LOCK_INIT.
REQ-022 i_block_lock=0 or i_enable=0 in any state SHALL force LOCK_INIT next cycle, overriding any simultaneous slot result.
REQ-023 o_am_flag SHALL assert, aligned with o_data, for each slot block evaluated in LOCKED state and for the locking slot block.
REQ-024 o_lane_id SHALL hold its last locked value after unlock.

Reset
REQ-025 i_reset SHALL asynchronously force LOCK_INIT and zero o_data, o_valid, o_am_flag, o_am_lock, o_lane_id, o_am_err_count, counter, invalid count; reset mid-lock SHALL restart acquisition from FIND_1ST.

Configuration
REQ-026 With AM_LOCK_ERR_CNT_EN defined, o_am_err_count SHALL increment (saturating at 0xFFFF) on each invalid AM in LOCKED and clear only on reset; without it, o_am_err_count SHALL be constant 0 and no counter logic is built.

Verification (AM_PERIOD=16, limit=3)
REQ-027 Lane-5 AM, 15 data blocks, lane-5 AM -> o_am_lock=1 one cycle after the second AM is sampled, o_lane_id=5, o_am_flag on that block.
REQ-028 Lane-5 AM then lane-7 AM at the slot -> no lock, FSM in FIND_1ST, next lane-7 AM starts a new candidate.
REQ-029 Locked, 2 corrupted AMs then a good AM then 3 corrupted AMs -> lock held until the third consecutive bad slot, then o_am_lock=0; o_am_err_count=5 with AM_LOCK_ERR_CNT_EN defined, 0 without it.
REQ-030 Locked, i_valid gaps of 3 cycles between blocks -> slot position unchanged, lock held, o_data/o_valid one cycle late.
REQ-031 Locked, i_block_lock dropped for 1 cycle coincident with a good AM -> o_am_lock=0 next cycle, reacquisition requires two AMs.
REQ-032 Assert i_reset while locked -> all outputs 0 immediately without a clock edge.
